// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the switch-capture sequencer.
// Playback state encoding and the default playback step length.
package capture_sequencer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // 1 s per entry at 100 MHz
    localparam int unsigned STEP_CYCLES_DFLT = 100_000_000;

endpackage

// File: rtl/capture_sequencer_step_timer.sv
// Playback step timer: free-running count with a terminal-count pulse.
// Restarts from zero whenever clr_i is high.
module step_timer #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic clk100_i,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned TW = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          last;

    assign last = (cnt_q == LAST);
    assign tc_o = en_i && last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last ? '0 : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk100_i or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Switch-capture controller: circular snapshot history, capture total,
// and timed LED replay of the history, oldest entry first.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DFLT
) (
    input  logic                       clk100_i,
    input  logic                       reset,
    input  logic                       clr_req_i,
    input  logic                       cap_req_i,
    input  logic                       play_req_i,
    input  logic [DATA_W-1:0]          sw_i,
    output logic [DATA_W-1:0]          ledr_o,
    output logic [7:0]                 count_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic [$clog2(DEPTH)-1:0]   pos_o,
    output logic                       playing_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [7:0]        count_q, count_d;
    logic [DATA_W-1:0] ledr_q, ledr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic              tc;
    logic              tmr_clr;
    logic [PW-1:0]     oldest;
    logic [PW-1:0]     rd_nxt;

    // A full history has fill[PW-1:0]==0, so oldest falls on wr_ptr.
    assign oldest  = wr_ptr_q - fill_q[PW-1:0];
    assign rd_nxt  = rd_ptr_q + PW'(1);
    assign tmr_clr = clr_req_i || cap_req_i || play_req_i
                     || (state_q != ST_PLAY);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk100_i (clk100_i),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (state_q == ST_PLAY),
        .tc_o     (tc)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pos_d    = pos_q;
        fill_d   = fill_q;
        count_d  = count_q;
        ledr_d   = ledr_q;
        wr_en    = 1'b0;
        if (clr_req_i) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            pos_d    = '0;
            fill_d   = '0;
            count_d  = '0;
            ledr_d   = '0;
        end else if (cap_req_i) begin
            wr_en    = 1'b1;
            state_d  = ST_IDLE;
            wr_ptr_d = wr_ptr_q + PW'(1);
            fill_d   = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
            count_d  = count_q + 8'd1;
            ledr_d   = sw_i;
            pos_d    = '0;
        end else if (state_q == ST_IDLE) begin
            if (play_req_i && fill_q != '0) begin
                state_d  = ST_PLAY;
                rd_ptr_d = oldest;
                pos_d    = '0;
                ledr_d   = mem_q[oldest];
            end
        end else if (play_req_i) begin
            state_d = ST_IDLE;
            pos_d   = '0;
        end else if (tc) begin
            if ({1'b0, pos_q} + FW'(1) < fill_q) begin
                pos_d    = pos_q + PW'(1);
                rd_ptr_d = rd_nxt;
                ledr_d   = mem_q[rd_nxt];
            end else begin
                state_d = ST_IDLE;
                pos_d   = '0;
            end
        end
    end

    always_ff @(posedge clk100_i or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pos_q    <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            ledr_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pos_q    <= pos_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            ledr_q   <= ledr_d;
        end
    end

    always_ff @(posedge clk100_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sw_i;
        end
    end

    assign ledr_o    = ledr_q;
    assign count_o   = count_q;
    assign fill_o    = fill_q;
    assign pos_o     = pos_q;
    assign playing_o = (state_q == ST_PLAY);

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer against a queue-based model
// of the capture history and playback timeline.
module tb_capture_sequencer;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int STEP   = 4;

    logic              clk;
    logic              rst_n;
    logic              clr_req;
    logic              cap_req;
    logic              play_req;
    logic [DATA_W-1:0] sw;
    logic [DATA_W-1:0] ledr;
    logic [7:0]        count;
    logic [2:0]        fill;
    logic [1:0]        pos;
    logic              playing;

    int checks = 0;
    int errors = 0;

    int hist[$];
    int m_count;
    int m_led;
    bit m_play;
    int m_el;

    capture_sequencer #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .STEP_CYCLES (STEP)
    ) dut (
        .clk100_i   (clk),
        .reset      (rst_n),
        .clr_req_i  (clr_req),
        .cap_req_i  (cap_req),
        .play_req_i (play_req),
        .sw_i       (sw),
        .ledr_o     (ledr),
        .count_o    (count),
        .fill_o     (fill),
        .pos_o      (pos),
        .playing_o  (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_count = 0;
        m_led   = 0;
        m_play  = 0;
        m_el    = 0;
    endtask

    task automatic model_step(input bit c, input bit k, input bit p, input int s);
        if (c) begin
            hist.delete();
            m_count = 0;
            m_led   = 0;
            m_play  = 0;
        end else if (k) begin
            hist.push_back(s);
            if (hist.size() > DEPTH) hist = hist[1:$];
            m_count = (m_count + 1) % 256;
            m_led   = s;
            m_play  = 0;
        end else if (!m_play) begin
            if (p && hist.size() > 0) begin
                m_play = 1;
                m_el   = 0;
                m_led  = hist[0];
            end
        end else if (p) begin
            m_play = 0;
        end else begin
            m_el++;
            if (m_el >= hist.size() * STEP) m_play = 0;
            else m_led = hist[m_el / STEP];
        end
    endtask

    task automatic check_all();
        chk("ledr", int'(ledr), m_led);
        chk("count", int'(count), m_count);
        chk("fill", int'(fill), hist.size());
        chk("pos", int'(pos), m_play ? m_el / STEP : 0);
        chk("playing", int'(playing), int'(m_play));
    endtask

    task automatic cycle(input bit c, input bit k, input bit p, input int s);
        clr_req  = c;
        cap_req  = k;
        play_req = p;
        sw       = DATA_W'(s);
        @(posedge clk);
        model_step(c, k, p, s & 'h3FF);
        @(negedge clk);
        clr_req  = 1'b0;
        cap_req  = 1'b0;
        play_req = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr_req  = 1'b0;
        cap_req  = 1'b0;
        play_req = 1'b0;
        sw       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // capture lands on the LEDs the next cycle
        cycle(0, 1, 0, 'h2A5);
        chk("s1_led", int'(ledr), 'h2A5);
        chk("s1_cnt", int'(count), 1);

        // six captures then a full replay of the last four
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cycle(0, 1, 0, i);
        cycle(0, 0, 1, 0);
        idle(STEP * DEPTH + 2);
        chk("s2_led", int'(ledr), 6);
        chk("s2_cnt", int'(count), 6);
        chk("s2_fill", int'(fill), 4);
        chk("s2_play", int'(playing), 0);

        // mid-playback capture, then a separate aborted replay
        cycle(0, 0, 1, 0);
        idle(STEP);
        chk("s4_pos", int'(pos), 1);
        cycle(0, 1, 0, 'h3FF);
        chk("s4_led", int'(ledr), 'h3FF);
        chk("s4_pos0", int'(pos), 0);
        cycle(0, 0, 1, 0);
        idle(STEP + 1);
        cycle(0, 0, 1, 0);
        chk("s4_abort_led", int'(ledr), 5);
        chk("s4_abort_play", int'(playing), 0);

        // request collisions
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("s3_empty_play", int'(playing), 0);
        cycle(0, 1, 1, 7);
        chk("s3_cap_play", int'(playing), 0);
        chk("s3_cap_led", int'(ledr), 7);
        cycle(1, 1, 0, 9);
        chk("s3_clr_cnt", int'(count), 0);
        chk("s3_clr_led", int'(ledr), 0);

        // total wraps independently of the history fill
        for (int i = 0; i < 256; i++) cycle(0, 1, 0, $urandom);
        chk("s5_wrap", int'(count), 0);
        chk("s5_fill", int'(fill), 4);
        cycle(0, 1, 0, $urandom);
        chk("s5_cnt1", int'(count), 1);

        // randomized request traffic
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            cycle(r < 2, r >= 2 && r < 14, (r % 9) == 0, $urandom);
        end

        // asynchronous reset in the middle of a replay
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, $urandom);
        cycle(0, 0, 1, 0);
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("s6_play", int'(playing), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 0);
        chk("s6_ign", int'(playing), 0);
        chk("s6_led", int'(ledr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
